// File: rtl/ip_arb_pkg.sv
// Shared definitions for the IP transmit arbiter: header field widths,
// the packed header record and the arbiter state encoding.
package ip_arb_pkg;

   localparam int IP_DSCP_W  = 6;
   localparam int IP_ECN_W   = 2;
   localparam int IP_LEN_W   = 16;
   localparam int IP_TTL_W   = 8;
   localparam int IP_PROTO_W = 8;
   localparam int IP_ADDR_W  = 32;

   typedef struct packed {
      logic [IP_DSCP_W-1:0]  dscp;
      logic [IP_ECN_W-1:0]   ecn;
      logic [IP_LEN_W-1:0]   length;
      logic [IP_TTL_W-1:0]   ttl;
      logic [IP_PROTO_W-1:0] protocol;
      logic [IP_ADDR_W-1:0]  source_ip;
      logic [IP_ADDR_W-1:0]  dest_ip;
   } ip_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational request picker: round-robin search starting at ptr, or
// fixed priority (lowest index) when rr_mode is low.
module arb_rr_pick #(
   parameter int N = 2,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             rr_mode,
   output logic [N-1:0]     grant_oh,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_vld
);

   always_comb begin
      int   base;
      int   idx;
      logic found;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      base      = rr_mode ? int'(ptr) : 0;
      // Walk the channels once, wrapping past N-1, and keep the first hit.
      for (int i = 0; i < N; i++) begin
         idx = (base + i) % N;
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = SEL_W'(idx);
         end
      end
      grant_vld = found;
   end

endmodule

// File: rtl/ip_tx_arb_mux.sv
// Frame-level N:1 arbiter merging IP header + payload sources onto one
// IP TX port; a grant is held from header acceptance through payload tlast.
module ip_tx_arb_mux
   import ip_arb_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int ROUND_ROBIN = 1,
   localparam int SEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS-1:0]            s_ip_hdr_valid,
   output logic [CHANNELS-1:0]            s_ip_hdr_ready,
   input  logic [CHANNELS*IP_DSCP_W-1:0]  s_ip_dscp,
   input  logic [CHANNELS*IP_ECN_W-1:0]   s_ip_ecn,
   input  logic [CHANNELS*IP_LEN_W-1:0]   s_ip_length,
   input  logic [CHANNELS*IP_TTL_W-1:0]   s_ip_ttl,
   input  logic [CHANNELS*IP_PROTO_W-1:0] s_ip_protocol,
   input  logic [CHANNELS*IP_ADDR_W-1:0]  s_ip_source_ip,
   input  logic [CHANNELS*IP_ADDR_W-1:0]  s_ip_dest_ip,
   input  logic [CHANNELS*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
   input  logic [CHANNELS*KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
   input  logic [CHANNELS-1:0]            s_ip_payload_axis_tvalid,
   output logic [CHANNELS-1:0]            s_ip_payload_axis_tready,
   input  logic [CHANNELS-1:0]            s_ip_payload_axis_tlast,
   input  logic [CHANNELS-1:0]            s_ip_payload_axis_tuser,
   output logic                           m_ip_hdr_valid,
   input  logic                           m_ip_hdr_ready,
   output logic [IP_DSCP_W-1:0]           m_ip_dscp,
   output logic [IP_ECN_W-1:0]            m_ip_ecn,
   output logic [IP_LEN_W-1:0]            m_ip_length,
   output logic [IP_TTL_W-1:0]            m_ip_ttl,
   output logic [IP_PROTO_W-1:0]          m_ip_protocol,
   output logic [IP_ADDR_W-1:0]           m_ip_source_ip,
   output logic [IP_ADDR_W-1:0]           m_ip_dest_ip,
   output logic [DATA_WIDTH-1:0]          m_ip_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]          m_ip_payload_axis_tkeep,
   output logic                           m_ip_payload_axis_tvalid,
   input  logic                           m_ip_payload_axis_tready,
   output logic                           m_ip_payload_axis_tlast,
   output logic                           m_ip_payload_axis_tuser,
   output logic [SEL_WIDTH-1:0]           grant_index,
   output logic                           busy
);

   arb_state_t            state, state_nxt;
   ip_hdr_t               hdr_ch [CHANNELS];
   ip_hdr_t               hdr_p1;
   logic [DATA_WIDTH-1:0] tdata_ch [CHANNELS];
   logic [SEL_WIDTH-1:0]  rr_ptr;
   logic [SEL_WIDTH-1:0]  pick_idx;
   logic [CHANNELS-1:0]   pick_oh;
   logic                  pick_vld;
   logic                  hdr_take;
   logic                  last_beat;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign hdr_ch[i] = '{
         dscp:      s_ip_dscp[i*IP_DSCP_W +: IP_DSCP_W],
         ecn:       s_ip_ecn[i*IP_ECN_W +: IP_ECN_W],
         length:    s_ip_length[i*IP_LEN_W +: IP_LEN_W],
         ttl:       s_ip_ttl[i*IP_TTL_W +: IP_TTL_W],
         protocol:  s_ip_protocol[i*IP_PROTO_W +: IP_PROTO_W],
         source_ip: s_ip_source_ip[i*IP_ADDR_W +: IP_ADDR_W],
         dest_ip:   s_ip_dest_ip[i*IP_ADDR_W +: IP_ADDR_W]
      };
      assign tdata_ch[i] = s_ip_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   arb_rr_pick #(.N(CHANNELS)) u_pick (
      .req       (s_ip_hdr_valid),
      .ptr       (rr_ptr),
      .rr_mode   (ROUND_ROBIN != 0),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .grant_vld (pick_vld)
   );

   assign hdr_take  = (state == ST_IDLE) && pick_vld;
   assign last_beat = (state == ST_PAYLOAD) && s_ip_payload_axis_tvalid[grant_index] &&
                      m_ip_payload_axis_tready && s_ip_payload_axis_tlast[grant_index];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (pick_vld)       state_nxt = ST_HDR;
         ST_HDR:     if (m_ip_hdr_ready) state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: if (last_beat)      state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   // Header capture, grant latch and round-robin pointer advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_p1      <= '0;
         grant_index <= '0;
         rr_ptr      <= '0;
      end else begin
         if (hdr_take) begin
            hdr_p1      <= hdr_ch[pick_idx];
            grant_index <= pick_idx;
         end
         if (last_beat && (ROUND_ROBIN != 0))
            rr_ptr <= (int'(grant_index) == CHANNELS - 1) ? '0 : grant_index + 1'b1;
      end
   end

   always_comb begin
      s_ip_hdr_ready           = '0;
      s_ip_payload_axis_tready = '0;
      m_ip_payload_axis_tdata  = '0;
      m_ip_payload_axis_tvalid = 1'b0;
      m_ip_payload_axis_tlast  = 1'b0;
      m_ip_payload_axis_tuser  = 1'b0;
      m_ip_hdr_valid           = (state == ST_HDR);
      busy                     = (state != ST_IDLE);
      if (hdr_take && rst_n) s_ip_hdr_ready = pick_oh;
      if (state == ST_PAYLOAD) begin
         s_ip_payload_axis_tready[grant_index] = m_ip_payload_axis_tready;
         m_ip_payload_axis_tdata  = tdata_ch[grant_index];
         m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid[grant_index];
         m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast[grant_index];
         m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser[grant_index];
      end
   end

   if (KEEP_ENABLE != 0) begin : g_keep
      logic [KEEP_WIDTH-1:0] tkeep_ch [CHANNELS];
      for (genvar i = 0; i < CHANNELS; i++) begin : g_kch
         assign tkeep_ch[i] = s_ip_payload_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
      assign m_ip_payload_axis_tkeep = (state == ST_PAYLOAD) ? tkeep_ch[grant_index] : '0;
   end else begin : g_no_keep
      logic unused_keep;
      assign unused_keep             = ^s_ip_payload_axis_tkeep;
      assign m_ip_payload_axis_tkeep = '1;
   end

   assign m_ip_dscp      = hdr_p1.dscp;
   assign m_ip_ecn       = hdr_p1.ecn;
   assign m_ip_length    = hdr_p1.length;
   assign m_ip_ttl       = hdr_p1.ttl;
   assign m_ip_protocol  = hdr_p1.protocol;
   assign m_ip_source_ip = hdr_p1.source_ip;
   assign m_ip_dest_ip   = hdr_p1.dest_ip;

endmodule

// File: tb/tb_ip_tx_arb_mux.sv
// Directed bench: a round-robin instance and a fixed-priority instance,
// both 4 channels x 32 bits, driven from the same source-side stimulus.
module tb_ip_tx_arb_mux;

   localparam int CH = 4;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [CH-1:0]    hdr_valid;
   logic [CH*6-1:0]  dscp;
   logic [CH*2-1:0]  ecn;
   logic [CH*16-1:0] len;
   logic [CH*8-1:0]  ttl;
   logic [CH*8-1:0]  proto;
   logic [CH*32-1:0] src_ip;
   logic [CH*32-1:0] dst_ip;
   logic [CH*DW-1:0] tdata;
   logic [CH*KW-1:0] tkeep;
   logic [CH-1:0]    tvalid, tlast, tuser;
   logic             m_hdr_ready, m_tready;

   logic [CH-1:0] hdr_ready_rr, tready_rr, hdr_ready_fp, tready_fp;
   logic          m_hdr_valid_rr, m_hdr_valid_fp;
   logic [5:0]    m_dscp_rr, m_dscp_fp;
   logic [1:0]    m_ecn_rr, m_ecn_fp;
   logic [15:0]   m_len_rr, m_len_fp;
   logic [7:0]    m_ttl_rr, m_ttl_fp, m_proto_rr, m_proto_fp;
   logic [31:0]   m_src_rr, m_src_fp, m_dst_rr, m_dst_fp;
   logic [DW-1:0] m_tdata_rr, m_tdata_fp;
   logic [KW-1:0] m_tkeep_rr, m_tkeep_fp;
   logic          m_tvalid_rr, m_tvalid_fp, m_tlast_rr, m_tlast_fp, m_tuser_rr, m_tuser_fp;
   logic [SW-1:0] grant_rr, grant_fp;
   logic          busy_rr, busy_fp;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ip_tx_arb_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .s_ip_hdr_valid(hdr_valid), .s_ip_hdr_ready(hdr_ready_rr),
      .s_ip_dscp(dscp), .s_ip_ecn(ecn), .s_ip_length(len), .s_ip_ttl(ttl),
      .s_ip_protocol(proto), .s_ip_source_ip(src_ip), .s_ip_dest_ip(dst_ip),
      .s_ip_payload_axis_tdata(tdata), .s_ip_payload_axis_tkeep(tkeep),
      .s_ip_payload_axis_tvalid(tvalid), .s_ip_payload_axis_tready(tready_rr),
      .s_ip_payload_axis_tlast(tlast), .s_ip_payload_axis_tuser(tuser),
      .m_ip_hdr_valid(m_hdr_valid_rr), .m_ip_hdr_ready(m_hdr_ready),
      .m_ip_dscp(m_dscp_rr), .m_ip_ecn(m_ecn_rr), .m_ip_length(m_len_rr), .m_ip_ttl(m_ttl_rr),
      .m_ip_protocol(m_proto_rr), .m_ip_source_ip(m_src_rr), .m_ip_dest_ip(m_dst_rr),
      .m_ip_payload_axis_tdata(m_tdata_rr), .m_ip_payload_axis_tkeep(m_tkeep_rr),
      .m_ip_payload_axis_tvalid(m_tvalid_rr), .m_ip_payload_axis_tready(m_tready),
      .m_ip_payload_axis_tlast(m_tlast_rr), .m_ip_payload_axis_tuser(m_tuser_rr),
      .grant_index(grant_rr), .busy(busy_rr)
   );

   ip_tx_arb_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .s_ip_hdr_valid(hdr_valid), .s_ip_hdr_ready(hdr_ready_fp),
      .s_ip_dscp(dscp), .s_ip_ecn(ecn), .s_ip_length(len), .s_ip_ttl(ttl),
      .s_ip_protocol(proto), .s_ip_source_ip(src_ip), .s_ip_dest_ip(dst_ip),
      .s_ip_payload_axis_tdata(tdata), .s_ip_payload_axis_tkeep(tkeep),
      .s_ip_payload_axis_tvalid(tvalid), .s_ip_payload_axis_tready(tready_fp),
      .s_ip_payload_axis_tlast(tlast), .s_ip_payload_axis_tuser(tuser),
      .m_ip_hdr_valid(m_hdr_valid_fp), .m_ip_hdr_ready(m_hdr_ready),
      .m_ip_dscp(m_dscp_fp), .m_ip_ecn(m_ecn_fp), .m_ip_length(m_len_fp), .m_ip_ttl(m_ttl_fp),
      .m_ip_protocol(m_proto_fp), .m_ip_source_ip(m_src_fp), .m_ip_dest_ip(m_dst_fp),
      .m_ip_payload_axis_tdata(m_tdata_fp), .m_ip_payload_axis_tkeep(m_tkeep_fp),
      .m_ip_payload_axis_tvalid(m_tvalid_fp), .m_ip_payload_axis_tready(m_tready),
      .m_ip_payload_axis_tlast(m_tlast_fp), .m_ip_payload_axis_tuser(m_tuser_fp),
      .grant_index(grant_fp), .busy(busy_fp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // One 2-beat frame on the round-robin instance, expecting channel ch.
   task automatic rr_frame(input int ch);
      settle();
      chk("rr_hdr_ready", hdr_ready_rr, 64'(1) << ch);
      chk("rr_idle_gap", busy_rr, 0);
      tick();
      chk("rr_grant", grant_rr, ch);
      chk("rr_hdr_valid", m_hdr_valid_rr, 1);
      chk("rr_dest", m_dst_rr, 32'hC0A8010A + ch);
      tick();
      tdata[ch*DW +: DW] = 32'hB0 + ch;
      tlast = '0;
      settle();
      chk("rr_beat1_data", m_tdata_rr, 32'hB0 + ch);
      chk("rr_beat1_last", m_tlast_rr, 0);
      tick();
      tlast[ch] = 1'b1;
      settle();
      chk("rr_beat2_last", m_tlast_rr, 1);
      tick();
      tlast = '0;
   endtask

   initial begin
      hdr_valid = '0; tdata = '0; tkeep = '0; tvalid = '0; tlast = '0; tuser = '0;
      m_hdr_ready = 1'b0; m_tready = 1'b0;
      for (int i = 0; i < CH; i++) begin
         dscp[i*6 +: 6]    = 6'(i + 1);
         ecn[i*2 +: 2]     = 2'(i);
         len[i*16 +: 16]   = 16'h0100 + 16'(i);
         ttl[i*8 +: 8]     = 8'(64 + i);
         proto[i*8 +: 8]   = 8'd17;
         src_ip[i*32 +: 32] = 32'h0A000000 + 32'(i);
         dst_ip[i*32 +: 32] = 32'hC0A8010A + 32'(i);
      end

      // Reset state, with a request present
      hdr_valid = 4'b0001;
      tick(); tick();
      settle();
      chk("rst_hdr_valid", m_hdr_valid_rr, 0);
      chk("rst_busy", busy_rr, 0);
      chk("rst_grant", grant_rr, 0);
      chk("rst_dest", m_dst_rr, 0);
      chk("rst_hdr_ready", hdr_ready_rr, 0);
      chk("rst_tvalid", m_tvalid_rr, 0);
      hdr_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Single 4-beat frame on ch0, ch1 presenting unrelated payload
      hdr_valid = 4'b0001;
      settle();
      chk("s1_hdr_ready", hdr_ready_rr, 4'b0001);
      chk("s1_hdr_valid_pre", m_hdr_valid_rr, 0);
      tick();
      hdr_valid = '0;
      settle();
      chk("s1_hdr_valid", m_hdr_valid_rr, 1);
      chk("s1_dest", m_dst_rr, 32'hC0A8010A);
      chk("s1_grant", grant_rr, 0);
      chk("s1_busy", busy_rr, 1);
      chk("s1_hdr_ready_hdr", hdr_ready_rr, 0);
      m_hdr_ready = 1'b1;
      tick();
      m_hdr_ready = 1'b0;
      m_tready = 1'b1;
      tdata[63:32] = 32'hDEADBEEF;
      tvalid[1] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tvalid[0] = 1'b1;
         tdata[31:0] = 32'hA0 + 32'(b);
         tkeep[3:0] = 4'hF;
         tlast[0] = (b == 3);
         settle();
         chk("s1_hdr_valid_pl", m_hdr_valid_rr, 0);
         chk("s1_tdata", m_tdata_rr, 32'hA0 + b);
         chk("s1_tvalid", m_tvalid_rr, 1);
         chk("s1_tlast", m_tlast_rr, (b == 3));
         chk("s1_tready", tready_rr, 4'b0001);
         tick();
      end
      tvalid = '0; tlast = '0;
      settle();
      chk("s1_done_busy", busy_rr, 0);
      chk("s1_done_tvalid", m_tvalid_rr, 0);

      // Reset on beat 3 of an 8-beat frame from ch2 (pointer now 1)
      tick();
      hdr_valid = 4'b0100;
      settle();
      chk("r_hdr_ready", hdr_ready_rr, 4'b0100);
      tick();
      hdr_valid = '0;
      chk("r_grant", grant_rr, 2);
      m_hdr_ready = 1'b1;
      tick();
      m_hdr_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         tvalid[2] = 1'b1;
         tdata[95:64] = 32'hC0 + 32'(b);
         tick();
      end
      tdata[95:64] = 32'hC2;
      settle();
      chk("r_beat3_tvalid", m_tvalid_rr, 1);
      rst_n = 1'b0;
      #1;
      chk("r_tvalid", m_tvalid_rr, 0);
      chk("r_tready", tready_rr, 0);
      chk("r_busy", busy_rr, 0);
      chk("r_grant0", grant_rr, 0);
      chk("r_dest", m_dst_rr, 0);
      chk("r_hdr_valid", m_hdr_valid_rr, 0);
      tvalid = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Round robin, all four channels requesting continuously
      hdr_valid = 4'hF;
      tvalid = 4'hF;
      m_hdr_ready = 1'b1;
      m_tready = 1'b1;
      rr_frame(0);
      rr_frame(1);
      rr_frame(2);
      rr_frame(3);
      rr_frame(0);
      hdr_valid = '0; tvalid = '0; tlast = '0;

      // Fixed priority vs round robin: ch1 and ch3 together three times, then ch3 alone
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      hdr_valid = 4'b1010;
      tvalid = 4'hF;
      tlast = 4'hF;
      for (int j = 0; j < 3; j++) begin
         settle();
         chk("fp_hdr_ready", hdr_ready_fp, 4'b0010);
         chk("rr2_hdr_ready", hdr_ready_rr, (j == 1) ? 4'b1000 : 4'b0010);
         tick();
         chk("fp_grant", grant_fp, 1);
         chk("rr2_grant", grant_rr, (j == 1) ? 3 : 1);
         tick();
         tick();
      end
      hdr_valid = 4'b1000;
      settle();
      chk("fp_hdr_ready_ch3", hdr_ready_fp, 4'b1000);
      chk("rr2_hdr_ready_ch3", hdr_ready_rr, 4'b1000);
      tick();
      chk("fp_grant_ch3", grant_fp, 3);
      chk("rr2_grant_ch3", grant_rr, 3);
      tick();
      tick();
      hdr_valid = '0; tvalid = '0; tlast = '0;

      // Backpressure, partial tkeep and tuser on ch2, ch0 queued meanwhile
      m_hdr_ready = 1'b0;
      m_tready = 1'b0;
      hdr_valid = 4'b0100;
      settle();
      chk("bp_hdr_ready", hdr_ready_rr, 4'b0100);
      tick();
      hdr_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("bp_hdr_valid_hold", m_hdr_valid_rr, 1);
         chk("bp_dest_hold", m_dst_rr, 32'hC0A8010C);
         chk("bp_len_hold", m_len_rr, 16'h0102);
         chk("bp_no_hdr_ready", hdr_ready_rr, 0);
         tick();
      end
      m_hdr_ready = 1'b1;
      tick();
      m_hdr_ready = 1'b0;
      tvalid[2] = 1'b1;
      tdata[95:64] = 32'h11223344;
      tkeep[11:8] = 4'hF;
      settle();
      chk("bp_tvalid", m_tvalid_rr, 1);
      chk("bp_tready_low", tready_rr, 0);
      tick();
      chk("bp_data_hold", m_tdata_rr, 32'h11223344);
      m_tready = 1'b1;
      settle();
      chk("bp_tready", tready_rr, 4'b0100);
      tick();
      m_tready = 1'b0;
      tdata[95:64] = 32'h55667788;
      tkeep[11:8] = 4'b0011;
      tlast[2] = 1'b1;
      tuser[2] = 1'b1;
      settle();
      chk("bp_tkeep", m_tkeep_rr, 4'b0011);
      chk("bp_tuser", m_tuser_rr, 1);
      chk("bp_tlast", m_tlast_rr, 1);
      chk("bp_tdata_last", m_tdata_rr, 32'h55667788);
      tick();
      chk("bp_last_held_busy", busy_rr, 1);
      chk("bp_last_held_tlast", m_tlast_rr, 1);
      chk("bp_queued_no_ready", hdr_ready_rr, 0);
      m_tready = 1'b1;
      tick();
      tvalid = '0; tlast = '0; tuser = '0;
      settle();
      chk("bp_end_busy", busy_rr, 0);
      chk("bp_queued_ready", hdr_ready_rr, 4'b0001);
      tick();
      hdr_valid = '0;
      chk("bp_queued_grant", grant_rr, 0);
      chk("bp_queued_dest", m_dst_rr, 32'hC0A8010A);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
